// File: rtl/sram_rw_port_ctrl.sv
// Request/response controller for the RW port (port 0) of a 1RW1R OpenRAM macro.
// Drives the macro pins straight from the accepted request and queues ordered responses in a credit-limited FIFO.
module sram_rw_port_ctrl #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [AW-1:0]                req_addr,
  input  logic [DW-1:0]                req_wdata,
  input  logic [DW/8-1:0]              req_wmask,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_we,
  output logic [DW-1:0]                rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         sram_csb0,
  output logic                         sram_web0,
  output logic [DW/8-1:0]              sram_wmask0,
  output logic [AW-1:0]                sram_addr0,
  output logic [DW-1:0]                sram_din0,
  input  logic [DW-1:0]                sram_dout0
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          inflight;
  logic          inflight_we;
  logic [DW:0]   store [DEPTH];
  logic [DW:0]   head;
  logic [DW-1:0] push_data;
  logic          fire;
  logic          push;
  logic          pop;

  // Credit covers both queued entries and the one still in the macro stage.
  assign occupancy = fifo_count + CW'(inflight);
  assign req_ready = rstn & (occupancy < CW'(DEPTH));
  assign fire      = req_valid & req_ready;

  assign sram_csb0   = ~fire;
  assign sram_web0   = ~(fire & req_we);
  assign sram_addr0  = req_addr;
  assign sram_din0   = req_wdata;
  assign sram_wmask0 = (fire & req_we) ? req_wmask : '0;

  assign push      = inflight;
  assign pop       = rsp_valid & rsp_ready;
  assign push_data = inflight_we ? '0 : sram_dout0;

  assign head      = store[rd_ptr];
  assign rsp_valid = (fifo_count != '0);
  assign rsp_we    = rsp_valid & head[DW];
  assign rsp_rdata = rsp_valid ? head[DW-1:0] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      inflight    <= fire;
      inflight_we <= fire & req_we;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: rsp_valid masks every entry not written since reset.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= {inflight_we, push_data};
  end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench for sram_rw_port_ctrl: macro behavioural model, request-level
// reference model (memory array + response queue), table vectors and random traffic.
module tb_sram_rw_port_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [7:0]    req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [31:0]   rsp_rdata;
  logic [2:0]    occupancy;
  logic          sram_csb0;
  logic          sram_web0;
  logic [3:0]    sram_wmask0;
  logic [7:0]    sram_addr0;
  logic [31:0]   sram_din0;
  logic [31:0]   sram_dout0;

  sram_rw_port_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .occupancy(occupancy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // Macro model: pins sampled at posedge, array access at the following negedge.
  logic [31:0] sram_mem [256];
  logic        lat_v, lat_we;
  logic [7:0]  lat_addr;
  logic [31:0] lat_din;
  logic [3:0]  lat_mask;

  initial begin
    lat_v = 1'b0;
    sram_dout0 = '0;
  end

  always @(posedge clk) begin
    lat_v    <= !sram_csb0;
    lat_we   <= !sram_web0;
    lat_addr <= sram_addr0;
    lat_din  <= sram_din0;
    lat_mask <= sram_wmask0;
  end

  always @(negedge clk) begin
    if (lat_v) begin
      if (lat_we) begin
        for (int b = 0; b < 4; b++)
          if (lat_mask[b]) sram_mem[lat_addr][8*b +: 8] <= lat_din[8*b +: 8];
      end else begin
        sram_dout0 <= sram_mem[lat_addr];
      end
    end
  end

  // Reference model: request-ordered memory plus queue of expected responses.
  typedef struct {
    bit          we;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [31:0] ref_mem [256];
  rsp_t        exp_q[$];
  rsp_t        tbl_q[$];
  rsp_t        pend;
  bit          pend_v;
  int          occ_m;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_v = 1'b0;
    occ_m  = 0;
  endtask

  // One clock: check at negedge, advance the model just after posedge.
  task automatic cycle(output bit fired);
    bit   exp_ready, fire, pop, we;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
    rsp_t h, t;
    @(negedge clk);
    exp_ready = rstn && (occ_m < DEPTH);
    fire = req_valid && exp_ready;
    pop  = rsp_ready && (exp_q.size() > 0);
    we = req_we; a = req_addr; d = req_wdata; m = req_wmask;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("occupancy", 64'(occupancy), 64'(occ_m));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
    chk("sram_csb0", 64'(sram_csb0), 64'(!fire));
    chk("sram_web0", 64'(sram_web0), 64'(!(fire && we)));
    chk("sram_wmask0", 64'(sram_wmask0), 64'((fire && we) ? m : 4'h0));
    if (fire) begin
      chk("sram_addr0", 64'(sram_addr0), 64'(a));
      chk("sram_din0", 64'(sram_din0), 64'(d));
    end
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("rsp_we", 64'(rsp_we), 64'(h.we));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(h.data));
      if (pop && tbl_q.size() > 0) begin
        t = tbl_q.pop_front();
        chk("tbl_rsp_we", 64'(rsp_we), 64'(t.we));
        chk("tbl_rsp_rdata", 64'(rsp_rdata), 64'(t.data));
      end
    end else begin
      chk("idle_rsp_we", 64'(rsp_we), 64'(0));
      chk("idle_rsp_rdata", 64'(rsp_rdata), 64'(0));
    end
    @(posedge clk);
    #1;
    if (pop) begin
      void'(exp_q.pop_front());
      occ_m--;
    end
    if (pend_v) exp_q.push_back(pend);
    pend_v = fire;
    if (fire) begin
      occ_m++;
      if (we) begin
        pend.we = 1'b1;
        pend.data = '0;
        for (int b = 0; b < 4; b++)
          if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        pend.we = 1'b0;
        pend.data = ref_mem[a];
      end
    end
    fired = fire;
  endtask

  task automatic send(input bit we, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] m, output int cycles);
    bit f;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    cycles = 0;
    f = 1'b0;
    while (!f && cycles < 50) begin
      cycle(f);
      cycles++;
    end
    if (!f) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance expected acceptance for addr %0h", a);
    end
  endtask

  task automatic drain();
    bit f;
    int n;
    req_valid = 1'b0;
    n = 0;
    while ((occ_m != 0 || pend_v) && n < 50) begin
      cycle(f);
      n++;
    end
    chk("drain_done", 64'(occ_m), 64'(0));
  endtask

  vec_t tbl [10];

  initial begin
    bit f;
    int c, total;
    logic [31:0] v;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ref_mem[i]  = v;
      sram_mem[i] = v;
    end
    model_reset();

    tbl[0] = '{1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 8'h05, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h10, 32'h11223344, 4'hF, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'h11BB33DD};
    tbl[5] = '{1'b1, 8'h7F, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 8'h7F, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 8'h20, 32'h12345678, 4'hF, 1'b1, 32'h0};
    tbl[8] = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 32'h12345678};

    // Reset values
    rstn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_we", 64'(rsp_we), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_csb0", 64'(sram_csb0), 64'(1));
    chk("rst_web0", 64'(sram_web0), 64'(1));
    cycle(f);
    cycle(f);
    req_valid = 1'b0;
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(1));

    // Directed vectors, back to back
    for (int i = 0; i < 10; i++) begin
      tbl_q.push_back('{tbl[i].exp_we, tbl[i].exp_rdata});
      send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, c);
      chk("tbl_accept_cycles", 64'(c), 64'(1));
    end
    drain();
    chk("tbl_all_seen", 64'(tbl_q.size()), 64'(0));

    // Stall: 4 credits, then backpressure holds off the rest
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), '0, '0, c);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h04;
    for (int i = 0; i < 3; i++) cycle(f);
    chk("stall_occupancy", 64'(occupancy), 64'(4));
    chk("stall_req_ready", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    send(1'b0, 8'h04, '0, '0, c);
    send(1'b0, 8'h05, '0, '0, c);
    drain();

    // Streaming reads across the address wrap
    total = 0;
    for (int i = 0; i < 256; i++) begin
      send(1'b0, 8'(i + 200), '0, '0, c);
      total += c;
    end
    chk("stream_cycles", 64'(total), 64'(256));
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_wmask = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle(f);
    end
    rsp_ready = 1'b1;
    drain();

    // Reset with 2 queued responses and 1 read in flight
    rsp_ready = 1'b0;
    send(1'b0, 8'h05, '0, '0, c);
    send(1'b0, 8'h10, '0, '0, c);
    send(1'b0, 8'h7F, '0, '0, c);
    chk("pre_rst_occupancy", 64'(occupancy), 64'(3));
    req_valid = 1'b1;
    rstn = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("async_rst_occupancy", 64'(occupancy), 64'(0));
    chk("async_rst_req_ready", 64'(req_ready), 64'(0));
    chk("async_rst_csb0", 64'(sram_csb0), 64'(1));
    model_reset();
    cycle(f);
    cycle(f);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cycle(f);
    send(1'b0, 8'h10, '0, '0, c);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
